// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP TX FIFO arbiter.
package udp_tx_pkg;

  localparam int unsigned STATUS_W        = 96;
  localparam int unsigned LEN_W           = 16;
  localparam int unsigned DEFAULT_MAX_LEN = 1472;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StWaitSt,
    StData,
    StStatus,
    StDone
  } state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Cyclic first-one selector: returns the first asserted request at or after the pointer,
// wrapping around; purely combinational.
module rr_priority_picker #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] cand [N];

  for (genvar g = 0; g < N; g++) begin : g_cand
    assign cand[g] = IdxW'((32'(ptr_i) + 32'(g)) % N);
  end

  // Walk from the farthest candidate back to the pointer so the closest one wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req_i[cand[k]]) begin
        idx_o   = cand[k];
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UDP TX data/status FIFO pair between
// N_SRC packet sources; a status word always follows exactly its own payload.
module udp_tx_arbiter
  import udp_tx_pkg::*;
#(
  parameter int unsigned N_SRC   = 2,
  parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_SRC-1:0]            src_req,
  input  logic [LEN_W*N_SRC-1:0]      src_len,
  input  logic [STATUS_W*N_SRC-1:0]   src_status,
  input  logic [8*N_SRC-1:0]          src_data,
  output logic [N_SRC-1:0]            src_grant,
  output logic [N_SRC-1:0]            src_rd,
  output logic [N_SRC-1:0]            src_done,
  output logic [N_SRC-1:0]            src_err,
  output logic [7:0]                  tx_fifo_data,
  output logic                        tx_fifo_data_write,
  input  logic                        tx_fifo_data_full,
  output logic [STATUS_W-1:0]         tx_fifo_status,
  output logic                        tx_fifo_status_write,
  input  logic                        tx_fifo_status_full,
  output logic                        busy,
  output logic [31:0]                 pkt_count,
  output logic [15:0]                 err_count
);

  localparam int unsigned IdxW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [31:0]         pkt_count_q, pkt_count_d;
  logic [15:0]         err_count_q, err_count_d;

  logic [LEN_W-1:0]    len_arr    [N_SRC];
  logic [STATUS_W-1:0] status_arr [N_SRC];
  logic [7:0]          data_arr   [N_SRC];

  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;
  logic                len_bad;

  for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
    assign len_arr[g]    = src_len[g*LEN_W +: LEN_W];
    assign status_arr[g] = src_status[g*STATUS_W +: STATUS_W];
    assign data_arr[g]   = src_data[g*8 +: 8];
  end

  rr_priority_picker #(
    .N    (N_SRC),
    .IdxW (IdxW)
  ) u_picker (
    .req_i   (src_req),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign len_bad = (len_q == '0) || (len_q > LEN_W'(MAX_LEN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      status_q    <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      status_q    <= status_d;
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    status_d    = status_q;
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          idx_d    = pick_idx;
          len_d    = len_arr[pick_idx];
          status_d = status_arr[pick_idx];
          state_d  = StGrant;
        end
      end
      StGrant: begin
        if (len_bad) begin
          if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          state_d = StDone;
        end else begin
          state_d = StWaitSt;
        end
      end
      // Reserve a status slot before committing any payload byte.
      StWaitSt: begin
        if (!tx_fifo_status_full) begin
          cnt_d   = len_q;
          state_d = StData;
        end
      end
      StData: begin
        if (!tx_fifo_data_full) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = StStatus;
        end
      end
      StStatus: begin
        pkt_count_d = pkt_count_q + 32'd1;
        state_d     = StDone;
      end
      StDone: begin
        rr_ptr_d = (idx_q == IdxW'(N_SRC - 1)) ? '0 : idx_q + IdxW'(1);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    src_grant            = '0;
    src_rd               = '0;
    src_done             = '0;
    src_err              = '0;
    tx_fifo_data         = '0;
    tx_fifo_data_write   = 1'b0;
    tx_fifo_status       = '0;
    tx_fifo_status_write = 1'b0;
    busy                 = (state_q != StIdle);
    case (state_q)
      StGrant: begin
        src_grant[idx_q] = 1'b1;
        if (len_bad) begin
          src_done[idx_q] = 1'b1;
          src_err[idx_q]  = 1'b1;
        end
      end
      StWaitSt: src_grant[idx_q] = 1'b1;
      StData: begin
        src_grant[idx_q]   = 1'b1;
        tx_fifo_data       = data_arr[idx_q];
        tx_fifo_data_write = ~tx_fifo_data_full;
        src_rd[idx_q]      = ~tx_fifo_data_full;
      end
      StStatus: begin
        src_grant[idx_q]     = 1'b1;
        tx_fifo_status       = status_q;
        tx_fifo_status_write = 1'b1;
        src_done[idx_q]      = 1'b1;
      end
      default: ;
    endcase
  end

  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter: table of single-packet vectors plus hand-written
// contention and mid-packet reset sequences.
module tb_udp_tx_arbiter;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int NSrc = 2;
  localparam int BufD = 2048;
  localparam int NVec = 6;

  localparam logic [95:0] ST0 = 96'hA5A50000_11112222_33330001;
  localparam logic [95:0] ST1 = 96'h5A5A0000_44445555_66660002;
  localparam logic [95:0] ST2 = 96'hC3C3FFFF_00000000_12340003;
  localparam logic [95:0] ST3 = 96'hDEAD0000_BEEF0000_00000004;
  localparam logic [95:0] ST4 = 96'h01234567_89ABCDEF_00000005;
  localparam logic [95:0] ST5 = 96'hFEDCBA98_76543210_00000006;

  logic                clk = 1'b0;
  logic                reset;
  logic [NSrc-1:0]     src_req;
  logic [16*NSrc-1:0]  src_len;
  logic [96*NSrc-1:0]  src_status;
  logic [8*NSrc-1:0]   src_data;
  logic [NSrc-1:0]     src_grant, src_rd, src_done, src_err;
  logic [7:0]          tx_fifo_data;
  logic                tx_fifo_data_write, tx_fifo_data_full;
  logic [95:0]         tx_fifo_status;
  logic                tx_fifo_status_write, tx_fifo_status_full;
  logic                busy;
  logic [31:0]         pkt_count;
  logic [15:0]         err_count;

  udp_tx_arbiter #(
    .N_SRC   (NSrc),
    .MAX_LEN (1472)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .src_req              (src_req),
    .src_len              (src_len),
    .src_status           (src_status),
    .src_data             (src_data),
    .src_grant            (src_grant),
    .src_rd               (src_rd),
    .src_done             (src_done),
    .src_err              (src_err),
    .tx_fifo_data         (tx_fifo_data),
    .tx_fifo_data_write   (tx_fifo_data_write),
    .tx_fifo_data_full    (tx_fifo_data_full),
    .tx_fifo_status       (tx_fifo_status),
    .tx_fifo_status_write (tx_fifo_status_write),
    .tx_fifo_status_full  (tx_fifo_status_full),
    .busy                 (busy),
    .pkt_count            (pkt_count),
    .err_count            (err_count)
  );

  always #4 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pbyte(input logic [7:0] b, input int k);
    return 8'(int'(b) * (k + 1));
  endfunction

  // Source model: show-ahead buffers advanced by src_rd.
  logic [7:0]      sbuf [NSrc][BufD];
  int              rdptr [NSrc];
  logic [NSrc-1:0] rd_s = '0;
  int              cyc = 0;

  always_comb begin
    for (int s = 0; s < NSrc; s++) src_data[8*s +: 8] = sbuf[s][rdptr[s] % BufD];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int s = 0; s < NSrc; s++) if (rd_s[s]) rdptr[s] <= rdptr[s] + 1;
  end

  // Monitor.
  typedef struct { int src; logic [7:0] b; int cyc; } wr_t;
  wr_t         wr_q [$];
  logic [95:0] st_q [$];
  int          done_cnt [NSrc];
  int          errp_cnt [NSrc];
  int          n_rd_bad = 0, n_wr_full = 0, n_st_nodone = 0, n_err_nodone = 0;

  always @(negedge clk) begin
    logic [NSrc-1:0] exp_rd;
    int gi;
    rd_s   = src_rd;
    exp_rd = tx_fifo_data_write ? src_grant : '0;
    if (src_rd !== exp_rd) n_rd_bad++;
    if (tx_fifo_data_write && tx_fifo_data_full) n_wr_full++;
    if (tx_fifo_data_write) begin
      gi = -1;
      for (int s = 0; s < NSrc; s++) if (src_grant[s]) gi = s;
      wr_q.push_back('{gi, tx_fifo_data, cyc});
    end
    if (tx_fifo_status_write) begin
      st_q.push_back(tx_fifo_status);
      if (src_done == '0) n_st_nodone++;
    end
    if ((src_err & ~src_done) != '0) n_err_nodone++;
    for (int s = 0; s < NSrc; s++) begin
      if (src_done[s]) done_cnt[s]++;
      if (src_err[s]) errp_cnt[s]++;
    end
  end

  // Driver.
  typedef struct { int src; logic [7:0] base; int len; logic [95:0] st; } pkt_t;
  pkt_t pend [$];

  task automatic load_pkt(input pkt_t p);
    int off;
    off = rdptr[p.src];
    for (int k = 0; k < p.len && k < BufD; k++) sbuf[p.src][(off + k) % BufD] = pbyte(p.base, k);
    src_len[16*p.src +: 16]    = 16'(p.len);
    src_status[96*p.src +: 96] = p.st;
    src_req[p.src]             = 1'b1;
  endtask

  // Call at posedge+1. Runs queued packets until all are done (or abort/timeout).
  task automatic run_traffic(input int max_cyc, input int stall_at, input int stall_n,
                             input int stfull_n, input int abort_at,
                             output bit timed_out, output int req_cyc);
    bit active [NSrc];
    int seen [NSrc];
    int w0, left;
    bit idle;
    timed_out = 1'b1;
    req_cyc   = cyc;
    left      = stall_n;
    w0        = wr_q.size();
    for (int s = 0; s < NSrc; s++) begin
      active[s] = 1'b0;
      seen[s]   = done_cnt[s];
    end
    for (int c = 0; c < max_cyc; c++) begin
      for (int s = 0; s < NSrc; s++) begin
        if (active[s] && done_cnt[s] != seen[s]) begin
          seen[s]    = done_cnt[s];
          active[s]  = 1'b0;
          src_req[s] = 1'b0;
        end
      end
      for (int s = 0; s < NSrc; s++) begin
        if (!active[s]) begin
          for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].src == s) begin
              load_pkt(pend[i]);
              pend.delete(i);
              active[s] = 1'b1;
              break;
            end
          end
        end
      end
      tx_fifo_status_full = (c < stfull_n);
      tx_fifo_data_full   = 1'b0;
      if (left > 0 && wr_q.size() - w0 == stall_at) begin
        tx_fifo_data_full = 1'b1;
        left--;
      end
      if (abort_at >= 0 && wr_q.size() - w0 == abort_at) begin
        reset     = 1'b1;
        src_req   = '0;
        timed_out = 1'b0;
        return;
      end
      idle = 1'b1;
      for (int s = 0; s < NSrc; s++) if (active[s]) idle = 1'b0;
      if (idle && pend.size() == 0) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    tx_fifo_data_full   = 1'b0;
    tx_fifo_status_full = 1'b0;
  endtask

  task automatic do_reset();
    reset               = 1'b1;
    src_req             = '0;
    tx_fifo_data_full   = 1'b0;
    tx_fifo_status_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int src; logic [7:0] base; int len; int stall_at; int stall_n; int stfull_n;
    logic [95:0] st; int exp_wr; bit exp_err; int exp_lat; int exp_pkt; int exp_errc;
  } vec_t;
  vec_t vt [NVec];

  int          ex_src [7];
  logic [7:0]  ex_b   [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got hang expected finish");
    $fatal(1);
  end

  initial begin
    bit to;
    int rq, w0, s0, d0, e0, rb0, wf0, sn0, en0, nb;

    vt[0] = '{0, 8'h11,    4, 0, 0,  0, ST0,    4, 1'b0,  3, 1, 0};
    vt[1] = '{1, 8'h03,    8, 3, 3,  0, ST1,    8, 1'b0,  3, 2, 0};
    vt[2] = '{0, 8'h21,    5, 0, 0, 10, ST2,    5, 1'b0, 11, 3, 0};
    vt[3] = '{1, 8'h44,    0, 0, 0,  0, ST3,    0, 1'b1, -1, 3, 1};
    vt[4] = '{0, 8'h55, 1473, 0, 0,  0, ST4,    0, 1'b1, -1, 3, 2};
    vt[5] = '{1, 8'h01, 1472, 0, 0,  0, ST5, 1472, 1'b0,  3, 4, 2};
    ex_src = '{0, 0, 0, 1, 1, 0, 0};
    ex_b   = '{8'h10, 8'h20, 8'h30, 8'hA0, 8'h40, 8'h50, 8'hA0};

    src_len    = '0;
    src_status = '0;
    do_reset();
    check("reset busy", 96'(busy), 96'(0));
    check("reset grant", 96'(src_grant), 96'(0));
    check("reset rd/done/err", 96'({src_rd, src_done, src_err}), 96'(0));
    check("reset fifo writes", 96'({tx_fifo_data_write, tx_fifo_status_write}), 96'(0));
    check("reset fifo data/status", 96'({tx_fifo_data, tx_fifo_status}), 96'(0));
    check("reset pkt_count", 96'(pkt_count), 96'(0));
    check("reset err_count", 96'(err_count), 96'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < NVec; v++) begin
      w0  = wr_q.size();
      s0  = st_q.size();
      d0  = done_cnt[vt[v].src];
      e0  = errp_cnt[vt[v].src];
      rb0 = n_rd_bad;
      wf0 = n_wr_full;
      sn0 = n_st_nodone;
      en0 = n_err_nodone;
      pend.push_back('{vt[v].src, vt[v].base, vt[v].len, vt[v].st});
      run_traffic(3000, vt[v].stall_at, vt[v].stall_n, vt[v].stfull_n, -1, to, rq);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("v%0d timeout", v), 96'(to), 96'(0));
      check($sformatf("v%0d data writes", v), 96'(wr_q.size() - w0), 96'(vt[v].exp_wr));
      nb = 0;
      for (int k = 0; k < wr_q.size() - w0; k++)
        if (wr_q[w0+k].b !== pbyte(vt[v].base, k) || wr_q[w0+k].src != vt[v].src) nb++;
      check($sformatf("v%0d bad bytes", v), 96'(nb), 96'(0));
      check($sformatf("v%0d status writes", v), 96'(st_q.size() - s0),
            96'(vt[v].exp_err ? 0 : 1));
      if (st_q.size() > s0) check($sformatf("v%0d status word", v), st_q[s0], vt[v].st);
      check($sformatf("v%0d done pulses", v), 96'(done_cnt[vt[v].src] - d0), 96'(1));
      check($sformatf("v%0d err pulses", v), 96'(errp_cnt[vt[v].src] - e0),
            96'(vt[v].exp_err));
      if (vt[v].exp_lat >= 0 && wr_q.size() > w0)
        check($sformatf("v%0d latency", v), 96'(wr_q[w0].cyc - rq), 96'(vt[v].exp_lat));
      check($sformatf("v%0d pkt_count", v), 96'(pkt_count), 96'(vt[v].exp_pkt));
      check($sformatf("v%0d err_count", v), 96'(err_count), 96'(vt[v].exp_errc));
      check($sformatf("v%0d rd vs write", v), 96'(n_rd_bad - rb0), 96'(0));
      check($sformatf("v%0d write while full", v), 96'(n_wr_full - wf0), 96'(0));
      check($sformatf("v%0d status without done", v), 96'(n_st_nodone - sn0), 96'(0));
      check($sformatf("v%0d err without done", v), 96'(n_err_nodone - en0), 96'(0));
      check($sformatf("v%0d busy after", v), 96'(busy), 96'(0));
    end

    // Contention: both request together, then src0 re-requests while src1 still waits.
    do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    w0 = wr_q.size();
    s0 = st_q.size();
    pend.push_back('{0, 8'h10, 3, ST0});
    pend.push_back('{1, 8'hA0, 2, ST1});
    pend.push_back('{0, 8'h50, 2, ST2});
    run_traffic(300, 0, 0, 0, -1, to, rq);
    repeat (2) @(posedge clk);
    #1;
    check("rr timeout", 96'(to), 96'(0));
    check("rr data writes", 96'(wr_q.size() - w0), 96'(7));
    nb = 0;
    for (int k = 0; k < 7 && w0 + k < wr_q.size(); k++)
      if (wr_q[w0+k].src != ex_src[k] || wr_q[w0+k].b !== ex_b[k]) nb++;
    check("rr byte order", 96'(nb), 96'(0));
    check("rr status writes", 96'(st_q.size() - s0), 96'(3));
    if (st_q.size() >= s0 + 3) begin
      check("rr status 1st", st_q[s0], ST0);
      check("rr status 2nd", st_q[s0+1], ST1);
      check("rr status 3rd", st_q[s0+2], ST2);
    end
    check("rr pkt_count", 96'(pkt_count), 96'(3));

    // Reset mid-packet, then simultaneous requests must restart from src0.
    s0 = st_q.size();
    pend.push_back('{0, 8'h11, 5, ST3});
    run_traffic(100, 0, 0, 0, 2, to, rq);
    check("abort reached", 96'(to), 96'(0));
    @(posedge clk); #1;
    check("abort busy", 96'(busy), 96'(0));
    check("abort grant", 96'(src_grant), 96'(0));
    check("abort rd/done/err", 96'({src_rd, src_done, src_err}), 96'(0));
    check("abort fifo writes", 96'({tx_fifo_data_write, tx_fifo_status_write}), 96'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort no status", 96'(st_q.size() - s0), 96'(0));
    check("abort pkt_count", 96'(pkt_count), 96'(0));
    w0 = wr_q.size();
    s0 = st_q.size();
    pend.push_back('{1, 8'h07, 2, ST5});
    pend.push_back('{0, 8'h09, 2, ST4});
    run_traffic(200, 0, 0, 0, -1, to, rq);
    repeat (2) @(posedge clk);
    #1;
    check("post-reset timeout", 96'(to), 96'(0));
    if (wr_q.size() > w0) check("post-reset first src", 96'(wr_q[w0].src), 96'(0));
    check("post-reset status writes", 96'(st_q.size() - s0), 96'(2));
    if (st_q.size() >= s0 + 2) begin
      check("post-reset status 1st", st_q[s0], ST4);
      check("post-reset status 2nd", st_q[s0+1], ST5);
    end
    check("post-reset pkt_count", 96'(pkt_count), 96'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
